wptr_full_ctrl: RTL

Write-side pointer and flag controller of the asynchronous FIFO, in the clk_wr domain. It accepts write requests and advances the binary write pointer. It publishes the registered Gray-coded write pointer, which a synchronizer carries into the read domain. It compares its own pointer with the read pointer, already synchronized into clk_wr, to produce full, almost-full, fill level and a sticky overflow flag.

---
 rtl/wptr_full_ctrl_pkg.sv | 18 +
 rtl/wptr_full_ctrl_gray2bin.sv | 17 +
 rtl/wptr_full_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/wptr_full_ctrl_pkg.sv
// Shared definitions for the FIFO pointer controllers (write side and read side).
// Gray codes here are reflected binary codes; pointers carry one extra wrap bit.
package wptr_full_ctrl_pkg;

    // Default RAM address width when the controller is instantiated without overrides.
    localparam int unsigned DEF_ADDR_WIDTH = 8;

    // Pointer width: one bit wider than the RAM address so full and empty are distinguishable.
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    // Default almost-full threshold: four free slots left.
    function automatic int unsigned def_af_thresh(input int unsigned addr_width);
        return (1 << addr_width) - 4;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position (a prefix XOR from the MSB down).
module wptr_full_ctrl_gray2bin #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // One reduction XOR per output bit; the tools share the common prefixes.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bin[gi] = ^gray[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and flag controller of the asynchronous FIFO (clk_wr domain).
// Advances the binary write pointer on accepted writes, publishes a registered
// Gray pointer for the read-domain synchronizer, and derives full, almost-full,
// fill level and a sticky overflow flag against the synchronized read pointer.
module wptr_full_ctrl
    import wptr_full_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_THRESH  = def_af_thresh(DEF_ADDR_WIDTH)
) (
    input  logic                  clk_wr,
    input  logic                  rst_wr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
    output logic                  wr_fire,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);

    // Mask that flips the two MSBs of a Gray pointer: a Gray pointer exactly one
    // FIFO depth ahead of another differs from it in precisely those two bits.
    localparam logic [PTR_W-1:0] FULL_MASK = ~({PTR_W{1'b1}} >> 2);
    localparam logic [PTR_W-1:0] AF_LEVEL  = PTR_W'(AF_THRESH);

    logic [PTR_W-1:0] wbin_q,  wbin_d;
    logic [PTR_W-1:0] wgray_q, wgray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             full_q,  full_d;
    logic             af_q,    af_d;
    logic             ovf_q,   ovf_d;
    logic [PTR_W-1:0] rbin;
    logic             fire;

    // Read pointer back to binary so the fill level is a plain subtraction.
    wptr_full_ctrl_gray2bin #(
        .WIDTH (PTR_W)
    ) u_rd_g2b (
        .gray (rd_ptr_gray_sync),
        .bin  (rbin)
    );

    // Next-state: accept a write unless full (or in reset), then re-derive all flags.
    always_comb begin
        fire    = wr_en & ~full_q & ~rst_wr;
        wbin_d  = wbin_q + PTR_W'(fire);
        wgray_d = wbin_d ^ (wbin_d >> 1);
        full_d  = (wgray_d == (rd_ptr_gray_sync ^ FULL_MASK));
        level_d = wbin_d - rbin;
        af_d    = (level_d >= AF_LEVEL);
        ovf_d   = ovf_q | (wr_en & full_q);
    end

    // State registers; reset returns the pointer and every flag to zero.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_fire     = fire;
    assign wr_addr     = wbin_q[ADDR_WIDTH-1:0];
    assign wr_ptr_gray = wgray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wr_level    = level_q;
    assign overflow    = ovf_q;

endmodule
